// File: rtl/i2c_write_master.sv
// i2c_write_master: START, three MSB-first bytes with ACK slots, STOP; I2C_ABORT_ON_NACK_EN stops after a NACKed byte
module i2c_write_master #(
    parameter int CLK_FREQ = 200000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i2c_data,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);
    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] phase_q, phase_d, byte_q, byte_d;
    logic [2:0] bit_q, bit_d;
    logic [23:0] sh_q, sh_d;
    logic ack_err_q, ack_err_d, scl_q, scl_d, oe_q, oe_d, tick, end_q;
    assign busy = state_q != IDLE && state_q != DONE;
    assign done = state_q == DONE;
    assign ack_err = ack_err_q;
    assign i2c_sclk = scl_q;
    assign i2c_sdat = oe_q ? 1'b0 : 1'bz;
    assign tick = busy && cnt_q == CW'(DIV - 1);
    assign end_q = tick && phase_q == 2'd3;
    // state and bus-pin registers; pins are registered from next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            phase_q <= '0;
            byte_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            ack_err_q <= 1'b0;
            scl_q <= 1'b1;
            oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            phase_q <= phase_d;
            byte_q <= byte_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            ack_err_q <= ack_err_d;
            scl_q <= scl_d;
            oe_q <= oe_d;
        end
    end
    // sequencing: each state spans four quarter-bit phases, then pin levels for the next phase
    always_comb begin
        state_d = state_q;
        cnt_d = busy ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
        phase_d = tick ? phase_q + 2'd1 : phase_q;
        byte_d = byte_q;
        bit_d = bit_q;
        sh_d = sh_q;
        ack_err_d = ack_err_q;
        case (state_q)
            IDLE: if (go) begin
                state_d = START;
                sh_d = i2c_data;
                ack_err_d = 1'b0;
                cnt_d = '0;
                phase_d = '0;
                bit_d = '0;
                byte_d = '0;
            end
            START: state_d = end_q ? BIT : START;
            BIT: if (end_q) begin
                sh_d = {sh_q[22:0], 1'b0};
                bit_d = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? ACK : BIT;
            end
            ACK: begin
                if (tick && phase_q == 2'd2 && i2c_sdat) ack_err_d = 1'b1;
                if (end_q) begin
                    byte_d = byte_q + 2'd1;
`ifdef I2C_ABORT_ON_NACK_EN
                    state_d = (byte_q == 2'd2 || ack_err_q) ? STOP : BIT;
`else
                    state_d = byte_q == 2'd2 ? STOP : BIT;
`endif
                end
            end
            STOP: state_d = end_q ? DONE : STOP;
            default: state_d = IDLE;
        endcase
        scl_d = 1'b1;
        oe_d = 1'b0;
        case (state_d)
            START: begin
                scl_d = phase_d < 2'd2;
                oe_d = 1'b1;
            end
            BIT: begin
                scl_d = phase_d == 2'd1 || phase_d == 2'd2;
                oe_d = !sh_d[23];
            end
            ACK: scl_d = phase_d == 2'd1 || phase_d == 2'd2;
            STOP: begin
                scl_d = phase_d != 2'd0;
                oe_d = phase_d < 2'd2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: directed transactions against a bus decoder and ACKing slave model
module tb_i2c_write_master;
  logic clk, rst_n, go, busy, done, ack_err, scl;
  logic [23:0] data;
  wire sda;
  int errors = 0, checks = 0, cyc = 0, acc = 0, lat, busy_low, nack_b = 3;
  int nstart = 0, nstop = 0, falls = 0, frame_n = 0, s0, extra;
  logic [26:0] cap = '0, frame_cap = '0;
  logic scl_p = 1'b1, sda_p = 1'b1, sl_drv = 1'b0;
  pullup (sda);
  assign sda = sl_drv ? 1'b0 : 1'bz;
  i2c_write_master #(.CLK_FREQ(80), .I2C_FREQ(5)) dut (
    .clk(clk), .rst_n(rst_n), .i2c_data(data), .go(go), .busy(busy),
    .done(done), .ack_err(ack_err), .i2c_sclk(scl), .i2c_sdat(sda)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (scl_p && scl && sda != sda_p) begin
      if (!sda) begin
        nstart++;
        cap = '0;
        falls = 0;
      end else begin
        nstop++;
        frame_cap = cap;
        frame_n = falls - 1;
      end
    end
    if (scl_p && !scl) begin
      falls++;
      if (falls >= 2) cap = {cap[25:0], sda_p};
    end
    sl_drv = (falls == 9 && nack_b != 0) || (falls == 18 && nack_b != 1) || (falls == 27 && nack_b != 2);
    scl_p = scl;
    sda_p = sda;
  end
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s: got %0h want %0h", t, o, e);
    end
  endtask
  task automatic start(input logic [23:0] d, input logic hold);
    @(negedge clk);
    data = d;
    go = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    go = hold;
  endtask
  task automatic wait_done(input int pulse_at, input logic hold, output int l);
    l = -1;
    busy_low = 0;
    for (int i = 0; i < 2000 && l < 0; i++) begin
      @(negedge clk);
      go = hold || (cyc - acc == pulse_at);
      if (done) l = cyc - acc;
      else if (!busy) busy_low++;
    end
    go = hold;
  endtask
  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ackerr", ack_err, 1'b0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    s0 = nstart;
    start(24'h340812, 1'b0);
    chk("t1_busy_accept", busy, 1'b1);
    wait_done(-1, 1'b0, lat);
    chk("t1_latency", lat, 464);
    chk("t1_busy_low", busy_low, 0);
    chk("t1_ackerr", ack_err, 1'b0);
    chk("t1_frame", frame_cap, {8'h34, 1'b0, 8'h08, 1'b0, 8'h12, 1'b0});
    chk("t1_nbits", frame_n, 27);
    chk("t1_starts", nstart, s0 + 1);
    chk("t1_stops", nstop, s0 + 1);
    nack_b = 1;
    start(24'h340812, 1'b0);
    wait_done(-1, 1'b0, lat);
    chk("t2_ackerr", ack_err, 1'b1);
`ifdef I2C_ABORT_ON_NACK_EN
    chk("t2_latency", lat, 320);
    chk("t2_frame", frame_cap, {9'd0, 8'h34, 1'b0, 8'h08, 1'b1});
    chk("t2_nbits", frame_n, 18);
`else
    chk("t2_latency", lat, 464);
    chk("t2_frame", frame_cap, {8'h34, 1'b0, 8'h08, 1'b1, 8'h12, 1'b0});
    chk("t2_nbits", frame_n, 27);
`endif
    nack_b = 2;
    s0 = nstart;
    start(24'h341201, 1'b1);
    wait_done(-1, 1'b1, lat);
    chk("t3a_latency", lat, 464);
    chk("t3a_ackerr", ack_err, 1'b1);
    chk("t3a_frame", frame_cap, {8'h34, 1'b0, 8'h12, 1'b0, 8'h01, 1'b1});
    nack_b = 3;
    @(negedge clk);
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_idle_ackerr", ack_err, 1'b1);
    @(negedge clk);
    acc = cyc;
    go = 1'b0;
    chk("t3b_busy_accept", busy, 1'b1);
    chk("t3b_ackerr_clear", ack_err, 1'b0);
    wait_done(-1, 1'b0, lat);
    chk("t3b_latency", lat, 464);
    chk("t3b_ackerr", ack_err, 1'b0);
    chk("t3b_frame", frame_cap, {8'h34, 1'b0, 8'h12, 1'b0, 8'h01, 1'b0});
    chk("t3_starts", nstart, s0 + 2);
    chk("t3_stops", nstop, s0 + 2);
    s0 = nstart;
    start(24'h340812, 1'b0);
    wait_done(200, 1'b0, lat);
    chk("t4_latency", lat, 464);
    chk("t4_frame", frame_cap, {8'h34, 1'b0, 8'h08, 1'b0, 8'h12, 1'b0});
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("t4_extra_activity", extra, 0);
    chk("t4_starts", nstart, s0 + 1);
    start(24'h340812, 1'b0);
    while (cyc - acc < 162) @(negedge clk);
    chk("t5_pre_scl", scl, 1'b0);
    chk("t5_pre_sda", sda, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_scl", scl, 1'b1);
    chk("t5_rst_sda", sda, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = nstop;
    start(24'h340812, 1'b0);
    wait_done(-1, 1'b0, lat);
    chk("t5_latency", lat, 464);
    chk("t5_frame", frame_cap, {8'h34, 1'b0, 8'h08, 1'b0, 8'h12, 1'b0});
    chk("t5_stops", nstop, s0 + 1);
    chk("t5_ackerr", ack_err, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
